// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side signals of the hazard controller.
//   master : CPU pipeline. It drives the IF/ID and ID/EX decode fields and the
//            branch outcome, and receives the enables, mux selects and counters.
//   slave  : hazard_ctrl.
// Ports:
//   ifid_ir[15:0]     instruction in ID (op[15:12] rs[11:10] rt[9:8] rd[7:6])
//   idex_regwrite     ID/EX producer writes a register
//   idex_wr[1:0]      ID/EX destination register
//   idex_memread      ID/EX producer is a load
//   branch_taken      EX resolved a taken branch this cycle
//   pc_write, ifid_write, ifid_flush, idex_bubble   pipeline control
//   fwd_a, fwd_b      EX-to-ID forwarding selects for the rs/rt reads
//   stall_cnt, flush_cnt   saturating performance counters
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      ifid_ir;
    logic             idex_regwrite;
    logic [1:0]       idex_wr;
    logic             idex_memread;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             fwd_a;
    logic             fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_ir, idex_regwrite, idex_wr, idex_memread, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_ir, idex_regwrite, idex_wr, idex_memread, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 3-stage IF/ID/EX CPU.
// Detects RAW and load-use hazards between the instruction in ID and the
// producer in EX, drives the forwarding selects, stalls or flushes the front
// of the pipeline, and counts stall and flush cycles.
// Ports:
//   clock    pipeline clock; state updates on the falling edge, like the
//            pipeline registers
//   reset_n  asynchronous active-low reset
//   bus      hazard_ctrl_if.slave (decode inputs, pipeline controls, counters)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue; hazards detected here start a stall
// ST_STALL | multi-cycle stall in progress, cnt = stall cycles still owed
module hazard_ctrl #(
    parameter bit FWD_EN     = 1'b1,
    parameter int RAW_STALL  = 1,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    hazard_ctrl_if.slave bus
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // The cycle that detects the hazard is itself a stall cycle, so the
    // counter is loaded with the number of additional cycles still needed.
    localparam logic [2:0] RAW_RELOAD  = 3'(RAW_STALL - 1);
    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_STALL - 1);

    state_t           state;
    logic [2:0]       cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic [3:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       rs_src;
    logic       rt_src;
    logic       hit_a;
    logic       hit_b;
    logic       load_use;
    logic       raw;
    logic       do_flush;
    logic       do_stall;

    assign op = bus.ifid_ir[15:12];
    assign rs = bus.ifid_ir[11:10];
    assign rt = bus.ifid_ir[9:8];

    // Only the all-zero nop reads no register; ADDI and LW use rt as a
    // destination, not a source.
    assign rs_src = |bus.ifid_ir;
    assign rt_src = (op <= 4'd6) || (op == 4'd9) || (op == 4'd10) || (op == 4'd11);

    assign hit_a = bus.idex_regwrite && (bus.idex_wr != 2'd0) && (bus.idex_wr == rs) && rs_src;
    assign hit_b = bus.idex_regwrite && (bus.idex_wr != 2'd0) && (bus.idex_wr == rt) && rt_src;

    assign load_use = bus.idex_memread && (hit_a || hit_b);
    assign raw      = !FWD_EN && (hit_a || hit_b) && !load_use;

    // A taken branch wins over everything, including an ongoing stall.
    assign do_flush = bus.branch_taken;
    assign do_stall = !bus.branch_taken && ((state == ST_STALL) || load_use || raw);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            cnt     <= 3'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (do_flush) begin
                state <= ST_RUN;
                cnt   <= 3'd0;
                if (flush_q != '1) flush_q <= flush_q + 1'b1;
            end else if (do_stall) begin
                if (stall_q != '1) stall_q <= stall_q + 1'b1;
                if (state == ST_STALL) begin
                    cnt <= (cnt != 3'd0) ? cnt - 3'd1 : 3'd0;
                    if (cnt <= 3'd1) state <= ST_RUN;
                end else if (load_use) begin
                    cnt   <= LOAD_RELOAD;
                    state <= (LOAD_RELOAD != 3'd0) ? ST_STALL : ST_RUN;
                end else begin
                    cnt   <= RAW_RELOAD;
                    state <= (RAW_RELOAD != 3'd0) ? ST_STALL : ST_RUN;
                end
            end
        end
    end

    // Reset forces the outputs directly so an unknown instruction word in
    // IF/ID cannot reach the pipeline controls while reset_n is low.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.ifid_write  = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b1;
        bus.fwd_a       = 1'b0;
        bus.fwd_b       = 1'b0;
        if (reset_n) begin
            if (do_flush) begin
                bus.pc_write    = 1'b1;
                bus.ifid_write  = 1'b1;
                bus.ifid_flush  = 1'b1;
                bus.idex_bubble = 1'b1;
            end else if (do_stall) begin
                bus.idex_bubble = 1'b1;
            end else begin
                bus.pc_write    = 1'b1;
                bus.ifid_write  = 1'b1;
                bus.idex_bubble = 1'b0;
                bus.fwd_a       = FWD_EN && hit_a && !bus.idex_memread;
                bus.fwd_b       = FWD_EN && hit_b && !bus.idex_memread;
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl. Two instances share the stimulus: one forwarding
// (FWD_EN=1, LOAD_STALL=2) and one stalling (FWD_EN=0, RAW_STALL=3,
// LOAD_STALL=1, 4-bit counters so saturation is reached).
module tb_hazard_ctrl;
    logic clock;
    logic reset_n;

    logic [15:0] cur_ir;
    logic        cur_rw;
    logic [1:0]  cur_wr;
    logic        cur_mr;
    logic        cur_br;

    hazard_ctrl_if #(.CNT_W(16)) bus_f ();
    hazard_ctrl_if #(.CNT_W(4))  bus_s ();

    assign bus_f.ifid_ir       = cur_ir;
    assign bus_f.idex_regwrite = cur_rw;
    assign bus_f.idex_wr       = cur_wr;
    assign bus_f.idex_memread  = cur_mr;
    assign bus_f.branch_taken  = cur_br;
    assign bus_s.ifid_ir       = cur_ir;
    assign bus_s.idex_regwrite = cur_rw;
    assign bus_s.idex_wr       = cur_wr;
    assign bus_s.idex_memread  = cur_mr;
    assign bus_s.branch_taken  = cur_br;

    hazard_ctrl #(.FWD_EN(1'b1), .RAW_STALL(1), .LOAD_STALL(2), .CNT_W(16)) dut_f (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_f.slave)
    );

    hazard_ctrl #(.FWD_EN(1'b0), .RAW_STALL(3), .LOAD_STALL(1), .CNT_W(4)) dut_s (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_s.slave)
    );

    logic [5:0]  out_f, out_s;
    logic [15:0] sc_f, fc_f;
    logic [3:0]  sc_s, fc_s;
    assign out_f = {bus_f.pc_write, bus_f.ifid_write, bus_f.ifid_flush,
                    bus_f.idex_bubble, bus_f.fwd_a, bus_f.fwd_b};
    assign out_s = {bus_s.pc_write, bus_s.ifid_write, bus_s.ifid_flush,
                    bus_s.idex_bubble, bus_s.fwd_a, bus_s.fwd_b};
    assign sc_f = bus_f.stall_cnt;
    assign fc_f = bus_f.flush_cnt;
    assign sc_s = bus_s.stall_cnt;
    assign fc_s = bus_s.flush_cnt;

    // output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b}
    localparam logic [5:0] V_RESET = 6'b000100;
    localparam logic [5:0] V_STALL = 6'b000100;
    localparam logic [5:0] V_FLUSH = 6'b111100;
    localparam logic [5:0] V_RUN   = 6'b110000;

    // per-instance reference parameters and state
    int fwd_en [2] = '{1, 0};
    int raw_st [2] = '{1, 3};
    int load_st[2] = '{2, 1};
    int cmax   [2] = '{65535, 15};
    int owed   [2];
    int scnt   [2];
    int fcnt   [2];

    int n_chk = 0;
    int n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owed[k] = 0;
            scnt[k] = 0;
            fcnt[k] = 0;
        end
    endtask

    // Expected outputs for this cycle from the hazard rules, then advance the
    // reference by one falling edge.
    task automatic model_eval(input int k, output logic [5:0] exp);
        int  op, rs, rt;
        bit  rs_src, rt_src, ha, hb, lu, raw, fa, fb;
        int  mode;
        op = int'(cur_ir[15:12]);
        rs = int'(cur_ir[11:10]);
        rt = int'(cur_ir[9:8]);
        rs_src = (cur_ir != 16'h0000);
        rt_src = (op <= 6) || (op >= 9 && op <= 11);
        ha = cur_rw && cur_wr != 0 && int'(cur_wr) == rs && rs_src;
        hb = cur_rw && cur_wr != 0 && int'(cur_wr) == rt && rt_src;
        lu = cur_mr && (ha || hb);
        raw = (fwd_en[k] == 0) && (ha || hb) && !lu;
        fa = 0;
        fb = 0;
        if (cur_br)           mode = 2;
        else if (owed[k] > 0) mode = 1;
        else if (lu || raw)   mode = 1;
        else begin
            mode = 0;
            fa = fwd_en[k] != 0 && ha && !cur_mr;
            fb = fwd_en[k] != 0 && hb && !cur_mr;
        end
        case (mode)
            0:       exp = V_RUN | {4'b0000, fa, fb};
            1:       exp = V_STALL;
            default: exp = V_FLUSH;
        endcase
        if (mode == 2) begin
            owed[k] = 0;
            if (fcnt[k] < cmax[k]) fcnt[k]++;
        end else if (mode == 1) begin
            if (scnt[k] < cmax[k]) scnt[k]++;
            if (owed[k] > 0)  owed[k]--;
            else if (lu)      owed[k] = load_st[k] - 1;
            else              owed[k] = raw_st[k] - 1;
        end
    endtask

    task automatic cycle(input logic [15:0] ir, input logic rw, input logic [1:0] wr,
                         input logic mr, input logic br);
        logic [5:0] e;
        @(posedge clock);
        reset_n = 1'b1;
        cur_ir = ir;
        cur_rw = rw;
        cur_wr = wr;
        cur_mr = mr;
        cur_br = br;
        #2;
        check("stall_cnt_f", 32'(sc_f), 32'(scnt[0]));
        check("flush_cnt_f", 32'(fc_f), 32'(fcnt[0]));
        check("stall_cnt_s", 32'(sc_s), 32'(scnt[1]));
        check("flush_cnt_s", 32'(fc_s), 32'(fcnt[1]));
        model_eval(0, e);
        check("outs_f", 32'(out_f), 32'(e));
        model_eval(1, e);
        check("outs_s", 32'(out_s), 32'(e));
    endtask

    task automatic do_reset(input int n);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        cur_ir = 'x;
        cur_rw = 1'bx;
        cur_wr = 'x;
        cur_mr = 1'bx;
        cur_br = 1'bx;
        model_reset();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(posedge clock);
            #1;
            check("rst_outs_f", 32'(out_f), 32'(V_RESET));
            check("rst_outs_s", 32'(out_s), 32'(V_RESET));
            check("rst_cnt_f", 32'({sc_f, fc_f}), 32'd0);
            check("rst_cnt_s", 32'({sc_s, fc_s}), 32'd0);
        end
    endtask

    // registers: $t1=1, $t2=2, $t3=3
    localparam logic [15:0] I_AND   = {4'h2, 2'd1, 2'd2, 2'd3, 6'd0};
    localparam logic [15:0] I_ADD   = {4'h1, 2'd1, 2'd2, 2'd3, 6'd0};
    localparam logic [15:0] I_RS0   = {4'h1, 2'd0, 2'd2, 2'd3, 6'd0};
    localparam logic [15:0] I_NOP   = 16'h0000;

    initial begin
        reset_n = 1'b0;
        cur_ir = 'x;
        cur_rw = 1'b0;
        cur_wr = 2'd0;
        cur_mr = 1'b0;
        cur_br = 1'b0;
        model_reset();
        do_reset(3);

        // ADDI $t1 in EX, AND $t3,$t1,$t2 in ID
        cycle(I_AND, 1'b1, 2'd1, 1'b0, 1'b0);
        check("fwd_pair_f", 32'(out_f), 32'(V_RUN | 6'b000010));
        check("raw_stall_s", 32'(out_s), 32'(V_STALL));
        repeat (3) cycle(I_NOP, 1'b0, 2'd0, 1'b0, 1'b0);
        check("raw_scnt_f", 32'(sc_f), 32'd0);
        check("raw_scnt_s", 32'(sc_s), 32'd3);

        // producer writes $0, consumer reads $0
        cycle(I_RS0, 1'b1, 2'd0, 1'b0, 1'b0);
        check("reg0_f", 32'(out_f), 32'(V_RUN));

        // LW $t1 then ADD $t1 consumer: two stall cycles on the forwarding unit
        cycle(I_ADD, 1'b1, 2'd1, 1'b1, 1'b0);
        cycle(I_ADD, 1'b0, 2'd0, 1'b0, 1'b0);
        check("lw_stall2_f", 32'(out_f), 32'(V_STALL));
        cycle(I_ADD, 1'b0, 2'd0, 1'b0, 1'b0);
        check("lw_after_f", 32'(out_f), 32'(V_RUN));
        check("lw_scnt_f", 32'(sc_f), 32'd2);

        // branch in the same cycle as a load-use hazard
        cycle(I_ADD, 1'b1, 2'd1, 1'b1, 1'b1);
        check("br_lu_f", 32'(out_f), 32'(V_FLUSH));
        cycle(I_NOP, 1'b0, 2'd0, 1'b0, 1'b0);
        check("br_fcnt_f", 32'(fc_f), 32'd1);
        check("br_scnt_f", 32'(sc_f), 32'd2);

        // branch aborting a multi-cycle stall on the stalling unit
        cycle(I_AND, 1'b1, 2'd1, 1'b0, 1'b0);
        cycle(I_AND, 1'b0, 2'd0, 1'b0, 1'b1);
        cycle(I_NOP, 1'b0, 2'd0, 1'b0, 1'b0);
        check("abort_s", 32'(out_s), 32'(V_RUN));

        // reset in the second cycle of a two-cycle load stall
        cycle(I_ADD, 1'b1, 2'd1, 1'b1, 1'b0);
        do_reset(2);
        cycle(I_ADD, 1'b1, 2'd1, 1'b0, 1'b0);
        check("post_rst_f", 32'(out_f), 32'(V_RUN | 6'b000010));

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ir;
            ir = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom)};
            if ($urandom_range(0, 9) == 0) ir = 16'h0000;
            if ($urandom_range(0, 499) == 0) do_reset(1);
            cycle(ir, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
        end
        cycle(I_NOP, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
